// File: rtl/noc_mem_ingress.sv
// rtl/noc_mem_ingress.sv - NoC packet classifier and FIFO ahead of the memory node
// Optional build macro NOC_MEM_INGRESS_STATS_EN adds saturating ifmap/filter/drop counters.
module noc_mem_ingress #(
    parameter int DATA_WIDTH = 18,
    parameter int WIDTH      = 4,
    parameter int MEM_INDEX  = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int RESULT_NUM = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pkt_in_valid,
    output logic                          pkt_in_ready,
    input  logic [DATA_WIDTH-1:0]         pkt_in_data,
    input  logic                          mem_loaded,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [DATA_WIDTH-1:0]         req_data,
    output logic [1:0]                    req_kind,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_drop,
    output logic                          all_done
`ifdef NOC_MEM_INGRESS_STATS_EN
    ,
    output logic [15:0]                   stat_ifmap,
    output logic [15:0]                   stat_filter,
    output logic [15:0]                   stat_drop
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(RESULT_NUM + 1);

    typedef enum logic [1:0] {
        WAIT_LOAD = 2'd0,
        RUN       = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic [CNT_W-1:0]      result_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic [1:0]            in_type, head_type;
    logic [WIDTH-1:0]      in_dest;
    logic                  full, empty, in_xfer, drop, push, pop, pop_result;

    assign in_type   = pkt_in_data[DATA_WIDTH-1 -: 2];
    assign in_dest   = pkt_in_data[DATA_WIDTH-3 -: WIDTH];
    assign head      = mem[rd_ptr];
    assign head_type = head[DATA_WIDTH-1 -: 2];

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);

    // rst_n gates ready so the router sees 0 while reset is held, not only after it.
    assign pkt_in_ready = rst_n && (state != DONE) && !full;
    assign req_valid    = (state == RUN) && !empty;
    assign all_done     = (state == DONE);
    assign fifo_level   = level;

    // Head is a registered array entry; zeroed when not presented.
    assign req_data = req_valid ? head : '0;
    assign req_kind = req_valid ? head_type : 2'b00;

    assign in_xfer    = pkt_in_valid && pkt_in_ready;
    assign drop       = in_xfer && ((in_type == 2'b11) || (in_dest != WIDTH'(MEM_INDEX)));
    assign push       = in_xfer && !drop;
    assign pop        = req_valid && req_ready;
    assign pop_result = pop && (head_type == 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOAD: if (mem_loaded) state_nxt = RUN;
            RUN:       if (pop_result && (result_cnt == CNT_W'(RESULT_NUM - 1))) state_nxt = DONE;
            DONE:      state_nxt = DONE;
            default:   state_nxt = WAIT_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            result_cnt <= '0;
            err_drop   <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_drop <= drop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop_result && (result_cnt != CNT_W'(RESULT_NUM)))
                result_cnt <= result_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pkt_in_data;
    end

`ifdef NOC_MEM_INGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ifmap  <= '0;
            stat_filter <= '0;
            stat_drop   <= '0;
        end else begin
            if (pop && (head_type == 2'b01) && (stat_ifmap != 16'hFFFF))
                stat_ifmap <= stat_ifmap + 1'b1;
            if (pop && (head_type == 2'b10) && (stat_filter != 16'hFFFF))
                stat_filter <= stat_filter + 1'b1;
            if (drop && (stat_drop != 16'hFFFF))
                stat_drop <= stat_drop + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_mem_ingress.sv
// tb/tb_noc_mem_ingress.sv - randomized self-checking bench for noc_mem_ingress against a queue model
module tb_noc_mem_ingress;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    logic [17:0] pkt_in_data;
    logic        mem_loaded;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_data;
    logic [1:0]  req_kind;
    logic [3:0]  fifo_level;
    logic        err_drop;
    logic        all_done;
`ifdef NOC_MEM_INGRESS_STATS_EN
    logic [15:0] stat_ifmap, stat_filter, stat_drop;
`endif

    always #5 clk = ~clk;

    noc_mem_ingress dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_in_valid (pkt_in_valid),
        .pkt_in_ready (pkt_in_ready),
        .pkt_in_data  (pkt_in_data),
        .mem_loaded   (mem_loaded),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_kind     (req_kind),
        .fifo_level   (fifo_level),
        .err_drop     (err_drop),
        .all_done     (all_done)
`ifdef NOC_MEM_INGRESS_STATS_EN
        ,
        .stat_ifmap   (stat_ifmap),
        .stat_filter  (stat_filter),
        .stat_drop    (stat_drop)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet queue plus loaded/done flags and a result tally.
    logic [17:0] q[$];
    bit          m_run, m_done, m_drop, accepted, rand_ready;
    int          m_results, m_si, m_sf, m_sd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(input logic [1:0] t, input logic [3:0] dest, input logic [7:0] pl);
        return {t, dest, 4'h5, pl};
    endfunction

    function automatic bit is_drop(input logic [17:0] p);
        return (p[17:16] == 2'b11) || (p[15:12] != 4'h0);
    endfunction

    task automatic model_clear();
        q.delete();
        m_run = 0; m_done = 0; m_drop = 0; m_results = 0;
        m_si = 0; m_sf = 0; m_sd = 0; accepted = 0;
    endtask

    task automatic cycle();
        bit          exp_ready, exp_valid, in_x, pop, was_run;
        logic [17:0] hd, inp;
        if (rand_ready) req_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_ready = !m_done && (q.size() < 8);
        exp_valid = m_run && !m_done && (q.size() > 0);
        check("pkt_in_ready", pkt_in_ready, exp_ready);
        check("req_valid", req_valid, exp_valid);
        check("fifo_level", fifo_level, q.size());
        check("err_drop", err_drop, m_drop);
        check("all_done", all_done, m_done);
        if (exp_valid) begin
            hd = q[0];
            check("req_data", req_data, hd);
            check("req_kind", req_kind, hd[17:16]);
        end
`ifdef NOC_MEM_INGRESS_STATS_EN
        check("stat_ifmap", stat_ifmap, m_si);
        check("stat_filter", stat_filter, m_sf);
        check("stat_drop", stat_drop, m_sd);
`endif
        in_x    = pkt_in_valid && exp_ready;
        pop     = exp_valid && req_ready;
        was_run = m_run;
        @(posedge clk);
        inp      = pkt_in_data;
        accepted = in_x;
        m_drop   = in_x && is_drop(inp);
        if (m_drop) m_sd++;
        if (pop) begin
            hd = q.pop_front();
            if (hd[17:16] == 2'b01) m_si++;
            if (hd[17:16] == 2'b10) m_sf++;
            if (hd[17:16] == 2'b00) begin
                m_results++;
                if (m_results == 9) m_done = 1;
            end
        end
        if (in_x && !m_drop) q.push_back(inp);
        if (!was_run && mem_loaded) m_run = 1;
        #1;
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_pkt_in_ready", pkt_in_ready, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_all_done", all_done, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_req_data", req_data, 0);
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [17:0] p, input int max_cycles);
        pkt_in_valid = 1'b1;
        pkt_in_data  = p;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (accepted) break;
        end
        check("send_accepted", accepted, 1);
        pkt_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit got10;
        rst_n = 1'b1; pkt_in_valid = 0; pkt_in_data = '0; mem_loaded = 0; req_ready = 0;
        rand_ready = 0;
        model_clear();
        #1;
        reset_mid();

        // gating: buffered while preload incomplete, then drained in order
        req_ready = 1;
        send(mk(2'b01, 4'h0, 8'h05), 4);
        send(mk(2'b01, 4'h0, 8'h06), 4);
        send(mk(2'b01, 4'h0, 8'h07), 4);
        idle(3);
        check("t2_level_held", fifo_level, 3);
        check("t2_no_valid", req_valid, 0);
        mem_loaded = 1;
        idle(6);
        check("t2_drained", fifo_level, 0);

        // drops: ready stays up, queue untouched
        req_ready = 0;
        send(mk(2'b11, 4'h0, 8'hA1), 2);
        send(mk(2'b01, 4'h3, 8'hA2), 2);
        idle(2);
        check("t3_level", fifo_level, 0);

        // full: 8 accepted, 9th held until a pop frees a slot
        reset_mid();
        mem_loaded = 1; req_ready = 0;
        for (int i = 0; i < 8; i++) send(mk(2'b10, 4'h0, 8'(i)), 3);
        pkt_in_valid = 1; pkt_in_data = mk(2'b01, 4'h0, 8'h99);
        cycle();
        check("t4_ninth_held", accepted, 0);
        req_ready = 1;
        cycle();
        check("t4_ninth_held_pop", accepted, 0);
        req_ready = 0;
        for (int i = 0; i < 3 && !accepted; i++) cycle();
        check("t4_ninth_taken", accepted, 1);
        pkt_in_valid = 0;
        idle(1);
        check("t4_level_full", fifo_level, 8);
        reset_mid();

        // done: nine results with random back-pressure, then input blocked
        mem_loaded = 1; rand_ready = 1;
        for (int i = 0; i < 9; i++) send(mk(2'b00, 4'h0, 8'(8'h40 + i)), 60);
        for (int i = 0; i < 200 && !m_done; i++) cycle();
        check("t5_done_model", m_done, 1);
        check("t5_all_done", all_done, 1);
        pkt_in_valid = 1; pkt_in_data = mk(2'b00, 4'h0, 8'h4A);
        got10 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            got10 |= accepted;
        end
        check("t5_tenth_blocked", got10, 0);
        check("t5_ready_low", pkt_in_ready, 0);
        pkt_in_valid = 0; rand_ready = 0;

`ifdef NOC_MEM_INGRESS_STATS_EN
        reset_mid();
        mem_loaded = 1; req_ready = 1;
        for (int i = 0; i < 4; i++) send(mk(2'b01, 4'h0, 8'(i)), 3);
        for (int i = 0; i < 2; i++) send(mk(2'b10, 4'h0, 8'(i)), 3);
        send(mk(2'b11, 4'h0, 8'hEE), 3);
        idle(4);
        check("t6_stat_ifmap", stat_ifmap, 4);
        check("t6_stat_filter", stat_filter, 2);
        check("t6_stat_drop", stat_drop, 1);
`endif

        // random traffic with periodic mid-traffic resets
        reset_mid();
        mem_loaded = 0; rand_ready = 1;
        for (int i = 0; i < 600; i++) begin
            logic [1:0] t;
            logic [3:0] d;
            if (i % 150 == 149) begin
                reset_mid();
                mem_loaded = 0;
            end
            if (!mem_loaded && ($urandom_range(0, 9) == 0)) mem_loaded = 1;
            t = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            pkt_in_valid = 1'($urandom_range(0, 1));
            pkt_in_data  = mk(t, d, 8'($urandom));
            cycle();
        end
        pkt_in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
